load_scoreboard: RTL and testbench

In-order scoreboard and issue controller for outstanding loads in the RISC-V pipeline. Tracks destination registers of loads issued to the non-blocking data memory and holds decode when an instruction reads or overwrites a register whose load data has not returned, or when the outstanding-load queue is full. Releases a hazard in the same cycle its memory response arrives, relying on the operand bypass network to forward the returning value. Sits between decode and the memory interface and feeds the writeback stage the register tag of each returning load.

---
 rtl/load_scoreboard_if.sv | 43 ++++
 rtl/load_scoreboard.sv | 103 ++++++++++
 tb/tb_load_scoreboard.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/load_scoreboard_if.sv
// Decode / memory-response / writeback signal bundle for the load scoreboard.
interface load_scoreboard_if #(
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 16
);
    localparam int PC_W = $clog2(MAX_PEND) + 1;

    logic             decValid;
    logic [4:0]       decRa1;
    logic [4:0]       decRa2;
    logic             decUsesRa1;
    logic             decUsesRa2;
    logic [4:0]       decRd;
    logic             decRegWrite;
    logic             decIsLoad;
    logic             flush;
    logic             memRespValid;

    logic             decReady;
    logic             issue;
    logic [4:0]       wbLoadRd;
    logic             wbLoadWrite;
    logic [1:0]       hazardCause;
    logic [PC_W-1:0]  pendCount;
    logic [CNT_W-1:0] stallCycles;
    logic             errSticky;

    // Pipeline side: drives decode and memory-response inputs.
    modport master (
        output decValid, decRa1, decRa2, decUsesRa1, decUsesRa2, decRd,
               decRegWrite, decIsLoad, flush, memRespValid,
        input  decReady, issue, wbLoadRd, wbLoadWrite, hazardCause,
               pendCount, stallCycles, errSticky
    );

    // Scoreboard side.
    modport slave (
        input  decValid, decRa1, decRa2, decUsesRa1, decUsesRa2, decRd,
               decRegWrite, decIsLoad, flush, memRespValid,
        output decReady, issue, wbLoadRd, wbLoadWrite, hazardCause,
               pendCount, stallCycles, errSticky
    );
endinterface

// File: rtl/load_scoreboard.sv
// In-order outstanding-load scoreboard: circular tag queue, RAW/WAW/full
// hazard detection for decode, and tag forwarding to writeback on return.
module load_scoreboard #(
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    load_scoreboard_if.slave sb
);
    localparam int PTR_W = $clog2(MAX_PEND);

    logic [PTR_W-1:0]              headPtr, tailPtr;
    logic [PTR_W:0]                count;
    logic [MAX_PEND-1:0][4:0]      tagQ;
    logic [CNT_W-1:0]              stallCnt;
    logic                          errQ;

    logic                          pop, full, enq;
    logic [MAX_PEND-1:0]           pendMask;
    logic                          rawHit, wawHit;
    logic [1:0]                    cause;
    logic                          ready;

    assign pop  = sb.memRespValid && (count != '0);
    assign full = (count == (PTR_W+1)'(MAX_PEND));

    // Mark live entries; the head being popped this cycle no longer blocks.
    always_comb begin
        logic [PTR_W-1:0] offs;
        pendMask = '0;
        for (int i = 0; i < MAX_PEND; i++) begin
            offs        = PTR_W'(i) - headPtr;
            pendMask[i] = ({1'b0, offs} < count) && !(pop && (offs == '0));
        end
    end

    // Compare decode register fields against pending tags; x0 never matches.
    always_comb begin
        rawHit = 1'b0;
        wawHit = 1'b0;
        for (int i = 0; i < MAX_PEND; i++) begin
            if (pendMask[i]) begin
                if (sb.decUsesRa1 && (sb.decRa1 != 5'd0) && (tagQ[i] == sb.decRa1)) rawHit = 1'b1;
                if (sb.decUsesRa2 && (sb.decRa2 != 5'd0) && (tagQ[i] == sb.decRa2)) rawHit = 1'b1;
                if (sb.decRegWrite && (sb.decRd != 5'd0) && (tagQ[i] == sb.decRd))  wawHit = 1'b1;
            end
        end
    end

    // Prioritised hazard cause: RAW, then WAW, then queue full.
    always_comb begin
        cause = 2'b00;
        if (rawHit)                            cause = 2'b01;
        else if (wawHit)                       cause = 2'b10;
        else if (sb.decIsLoad && full && !pop) cause = 2'b11;
    end

    assign ready          = (cause == 2'b00);
    assign enq            = sb.issue && sb.decIsLoad;
    assign sb.hazardCause = cause;
    assign sb.decReady    = ready;
    assign sb.issue       = sb.decValid && ready && !sb.flush;
    assign sb.wbLoadRd    = (count != '0) ? tagQ[headPtr] : 5'd0;
    assign sb.wbLoadWrite = pop && (tagQ[headPtr] != 5'd0);
    assign sb.pendCount   = count;
    assign sb.stallCycles = stallCnt;
    assign sb.errSticky   = errQ;

    // Queue pointers, occupancy and tag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            tagQ    <= '0;
        end else begin
            if (enq) begin
                tagQ[tailPtr] <= sb.decRegWrite ? sb.decRd : 5'd0;
                tailPtr       <= tailPtr + 1'b1;
            end
            if (pop) headPtr <= headPtr + 1'b1;
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Saturating stall counter and sticky empty-response error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
            errQ     <= 1'b0;
        end else begin
            if (sb.decValid && !ready && !sb.flush && (stallCnt != '1))
                stallCnt <= stallCnt + 1'b1;
            if (sb.memRespValid && (count == '0))
                errQ <= 1'b1;
        end
    end
endmodule

// File: tb/tb_load_scoreboard.sv
// Directed table-driven bench for load_scoreboard (MAX_PEND 4, CNT_W 4).
module tb_load_scoreboard;
    localparam int MP = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    load_scoreboard_if #(.MAX_PEND(MP), .CNT_W(CW)) sbIf ();
    load_scoreboard #(.MAX_PEND(MP), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbIf.slave)
    );

    typedef struct {
        int v, ra1, ra2, u1, u2, rd, rw, ld, fl, rsp;
        int rdy, iss, hz, wbRd, wbW, pc, st, err;
    } vec_t;

    vec_t vecs[27];
    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t x);
        sbIf.decValid     = (x.v   != 0);
        sbIf.decRa1       = 5'(x.ra1);
        sbIf.decRa2       = 5'(x.ra2);
        sbIf.decUsesRa1   = (x.u1  != 0);
        sbIf.decUsesRa2   = (x.u2  != 0);
        sbIf.decRd        = 5'(x.rd);
        sbIf.decRegWrite  = (x.rw  != 0);
        sbIf.decIsLoad    = (x.ld  != 0);
        sbIf.flush        = (x.fl  != 0);
        sbIf.memRespValid = (x.rsp != 0);
    endtask

    function automatic vec_t mk(input int v, ra1, ra2, u1, u2, rd, rw, ld, fl, rsp,
                                input int rdy, iss, hz, wbRd, wbW, pc, st, err);
        vec_t r;
        r.v = v; r.ra1 = ra1; r.ra2 = ra2; r.u1 = u1; r.u2 = u2; r.rd = rd;
        r.rw = rw; r.ld = ld; r.fl = fl; r.rsp = rsp;
        r.rdy = rdy; r.iss = iss; r.hz = hz; r.wbRd = wbRd; r.wbW = wbW;
        r.pc = pc; r.st = st; r.err = err;
        return r;
    endfunction

    task automatic idle();
        drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    endtask

    initial begin
        //          v ra1 ra2 u1 u2 rd rw ld fl rsp | rdy iss hz wbRd wbW pc st err
        vecs[0]  = mk(1, 2, 0, 1, 0, 5, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0); // load x5
        vecs[1]  = mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0,   0, 0, 1, 5, 0, 1, 0, 0); // RAW x5
        vecs[2]  = mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0,   0, 0, 1, 5, 0, 1, 1, 0);
        vecs[3]  = mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 0,   0, 0, 1, 5, 0, 1, 2, 0);
        vecs[4]  = mk(1, 5, 0, 1, 0, 6, 1, 0, 0, 1,   1, 1, 0, 5, 1, 1, 3, 0); // released by resp
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 3, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 3, 0); // loads x1..x4
        vecs[7]  = mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0,   1, 1, 0, 1, 0, 1, 3, 0);
        vecs[8]  = mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0,   1, 1, 0, 1, 0, 2, 3, 0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0,   1, 1, 0, 1, 0, 3, 3, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 8, 1, 1, 0, 0,   0, 0, 3, 1, 0, 4, 3, 0); // full
        vecs[11] = mk(1, 0, 0, 0, 0, 8, 1, 1, 0, 1,   1, 1, 0, 1, 1, 4, 4, 0); // full + pop
        vecs[12] = mk(1, 3, 0, 0, 0, 3, 1, 0, 0, 0,   0, 0, 2, 2, 0, 4, 4, 0); // WAW x3, ra1 unused
        vecs[13] = mk(1, 4, 0, 1, 0, 3, 1, 0, 0, 0,   0, 0, 1, 2, 0, 4, 5, 0); // RAW beats WAW
        vecs[14] = mk(1, 0, 3, 0, 1, 9, 1, 0, 1, 0,   0, 0, 1, 2, 0, 4, 6, 0); // RAW x3 + flush
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 2, 1, 4, 6, 0); // drain 2,3,4,8
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 3, 1, 3, 6, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 4, 1, 2, 6, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 8, 1, 1, 6, 0);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 6, 0); // load x0
        vecs[20] = mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 1, 6, 0); // read/write x0
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 1, 6, 0); // x0 returns, no write
        vecs[22] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 6, 0); // load x7
        vecs[23] = mk(1, 1, 0, 1, 0, 7, 1, 0, 0, 0,   0, 0, 2, 7, 0, 1, 6, 0); // addi x7: WAW
        vecs[24] = mk(1, 1, 0, 1, 0, 7, 1, 0, 0, 1,   1, 1, 0, 7, 1, 1, 7, 0);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 7, 0); // resp when empty
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 7, 1);

        // Reset state, with a valid decode present during reset.
        rst_n = 1'b0;
        idle();
        sbIf.decValid = 1'b1;
        #1;
        chk("rst_decReady", int'(sbIf.decReady), 1);
        chk("rst_issue", int'(sbIf.issue), 1);
        chk("rst_hazard", int'(sbIf.hazardCause), 0);
        chk("rst_pendCount", int'(sbIf.pendCount), 0);
        chk("rst_wbLoadWrite", int'(sbIf.wbLoadWrite), 0);
        chk("rst_stall", int'(sbIf.stallCycles), 0);
        chk("rst_err", int'(sbIf.errSticky), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_decReady", i), int'(sbIf.decReady), vecs[i].rdy);
            chk($sformatf("v%0d_issue", i), int'(sbIf.issue), vecs[i].iss);
            chk($sformatf("v%0d_hazard", i), int'(sbIf.hazardCause), vecs[i].hz);
            chk($sformatf("v%0d_wbLoadRd", i), int'(sbIf.wbLoadRd), vecs[i].wbRd);
            chk($sformatf("v%0d_wbLoadWrite", i), int'(sbIf.wbLoadWrite), vecs[i].wbW);
            chk($sformatf("v%0d_pendCount", i), int'(sbIf.pendCount), vecs[i].pc);
            chk($sformatf("v%0d_stall", i), int'(sbIf.stallCycles), vecs[i].st);
            chk($sformatf("v%0d_err", i), int'(sbIf.errSticky), vecs[i].err);
        end

        // Reset mid-queue with three pending loads (x10, x11, x12).
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(mk(1,0,0,0,0,10+i,1,1,0,0, 0,0,0,0,0,0,0,0));
        end
        @(negedge clk);
        drive(mk(1,11,0,1,0,13,1,0,0,0, 0,0,0,0,0,0,0,0));
        #1;
        chk("mid_pendCount", int'(sbIf.pendCount), 3);
        chk("mid_hazard", int'(sbIf.hazardCause), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_pendCount", int'(sbIf.pendCount), 0);
        chk("arst_decReady", int'(sbIf.decReady), 1);
        chk("arst_issue", int'(sbIf.issue), 1);
        chk("arst_err", int'(sbIf.errSticky), 0);
        chk("arst_stall", int'(sbIf.stallCycles), 0);
        @(negedge clk);
        rst_n = 1'b1;
        // Late response for a discarded load.
        drive(mk(0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0));
        #1;
        chk("late_wbLoadWrite", int'(sbIf.wbLoadWrite), 0);
        chk("late_wbLoadRd", int'(sbIf.wbLoadRd), 0);
        @(negedge clk);
        idle();
        #1;
        chk("late_err", int'(sbIf.errSticky), 1);
        chk("late_pendCount", int'(sbIf.pendCount), 0);

        // Stall counter saturation under persistent RAW on x9.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(mk(1,0,0,0,0,9,1,1,0,0, 0,0,0,0,0,0,0,0));
        @(negedge clk);
        drive(mk(1,0,9,0,1,14,1,0,0,0, 0,0,0,0,0,0,0,0));
        for (int i = 0; i < 20; i++) @(negedge clk);
        #1;
        chk("sat_stall", int'(sbIf.stallCycles), 15);
        chk("sat_decReady", int'(sbIf.decReady), 0);
        chk("sat_pendCount", int'(sbIf.pendCount), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
